// File: rtl/imem_loader.sv
// Instruction memory loader: turns a little-endian byte stream into BRAM word writes.
// The stream is a 4-byte word count N followed by N 4-byte words, all little-endian.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   in_valid/in_data/in_ready - upstream byte handshake (transfer = in_valid & in_ready)
//   we/waddr/wdata  - BRAM write port (byte address, one we pulse per word)
//   loading         - load in progress (core fetch held off)
//   done / err      - image written / length too large; both sticky until reset
module imem_loader #(
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [7:0]  waddr,
  output logic [31:0] wdata,
  output logic        loading,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W = 7;

  typedef enum logic [2:0] {LEN, DATA, WR, DONE, ERR} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         byte_cnt;
  logic [IDX_W-1:0]   word_idx;
  logic [31:0]        len_n;
  // Low three bytes of the word being assembled; the fourth byte comes straight from in_data.
  logic [23:0]        asm_bytes;
  logic               accept;
  logic               last_byte;
  logic [31:0]        full_word;
  logic [31:0]        idx_inc;

  // Ready only in the byte-consuming states, and never while reset is held.
  assign in_ready  = (state == LEN || state == DATA) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign full_word = {in_data, asm_bytes};
  assign idx_inc   = 32'(word_idx) + 32'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LEN;
    else     state <= state_nxt;
  end

  // Next-state logic; the length check uses the full 32-bit count.
  always_comb begin
    state_nxt = state;
    case (state)
      LEN: begin
        if (last_byte) begin
          if (full_word == 32'd0)                   state_nxt = DONE;
          else if (full_word > 32'(MAX_WORDS))      state_nxt = ERR;
          else                                      state_nxt = DATA;
        end
      end
      DATA: if (last_byte) state_nxt = WR;
      WR: begin
        if (idx_inc == len_n) state_nxt = DONE;
        else                  state_nxt = DATA;
      end
      DONE:    state_nxt = DONE;
      ERR:     state_nxt = ERR;
      default: state_nxt = LEN;
    endcase
  end

  // Byte assembly, counters and the registered write port / status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= 2'd0;
      word_idx  <= '0;
      len_n     <= 32'd0;
      asm_bytes <= 24'd0;
      we        <= 1'b0;
      waddr     <= 8'd0;
      wdata     <= 32'd0;
      loading   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt  <= byte_cnt + 2'd1;
        asm_bytes <= {in_data, asm_bytes[23:8]};
      end
      if (last_byte && state == LEN) len_n <= full_word;
      // Capture the write on the accepting edge so we pulses the very next cycle.
      if (last_byte && state == DATA) begin
        wdata <= full_word;
        waddr <= {word_idx[5:0], 2'b00};
      end
      if (state == WR) begin
        word_idx <= word_idx + IDX_W'(1);
        byte_cnt <= 2'd0;
      end
      we      <= (state_nxt == WR);
      loading <= (state_nxt == LEN) || (state_nxt == DATA) || (state_nxt == WR);
      done    <= (state_nxt == DONE);
      err     <= (state_nxt == ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        loading;
  logic        done;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  addr_q[$];
  logic [31:0] data_q[$];

  imem_loader #(.MAX_WORDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .loading  (loading),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Record every BRAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      addr_q.push_back(waddr);
      data_q.push_back(wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Offer one byte (after optional idle gap) and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit ok;
    int gap;
    ok  = 1'b0;
    gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      bit r;
      r = in_ready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete();
    data_q.delete();
  endtask

  logic [31:0] exp_w;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready",   32'(in_ready), 32'd0);
    chk("rst_loading", 32'(loading),  32'd1);
    chk("rst_done",    32'(done),     32'd0);
    chk("rst_err",     32'(err),      32'd0);
    chk("rst_we",      32'(we),       32'd0);
    chk("rst_waddr",   32'(waddr),    32'd0);
    chk("rst_wdata",   wdata,         32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(in_ready), 32'd1);

    // Two-word image back to back
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0740_00EF, 0);
    idle();
    repeat (2) @(negedge clk);
    chk("b2b_count", 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      chk("b2b_a0", 32'(addr_q[0]), 32'h00);
      chk("b2b_d0", data_q[0],      32'h0000_0013);
      chk("b2b_a1", 32'(addr_q[1]), 32'h04);
      chk("b2b_d1", data_q[1],      32'h0740_00EF);
    end
    chk("b2b_done",    32'(done),     32'd1);
    chk("b2b_loading", 32'(loading),  32'd0);
    chk("b2b_ready",   32'(in_ready), 32'd0);

    // Empty image
    do_reset();
    send_word(32'd0, 0);
    idle();
    chk("n0_done",    32'(done),     32'd1);
    chk("n0_ready",   32'(in_ready), 32'd0);
    chk("n0_loading", 32'(loading),  32'd0);
    repeat (3) @(negedge clk);
    chk("n0_nowrite", 32'(addr_q.size()), 32'd0);

    // Length one past capacity
    do_reset();
    send_word(32'd65, 0);
    idle();
    chk("n65_err",     32'(err),      32'd1);
    chk("n65_ready",   32'(in_ready), 32'd0);
    chk("n65_loading", 32'(loading),  32'd0);
    chk("n65_done",    32'(done),     32'd0);
    repeat (4) @(negedge clk);
    chk("n65_nowrite", 32'(addr_q.size()), 32'd0);

    // Large count must not be truncated
    do_reset();
    send_word(32'h0000_0100, 0);
    idle();
    chk("n256_err",  32'(err),  32'd1);
    chk("n256_done", 32'(done), 32'd0);

    // Full 64-word image
    do_reset();
    send_word(32'd64, 0);
    for (int i = 0; i < 64; i++) send_word(32'h1000_0000 + 32'(i) * 32'h0000_0101, 0);
    idle();
    repeat (3) @(negedge clk);
    chk("full_count", 32'(addr_q.size()), 32'd64);
    if (addr_q.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        chk("full_addr", 32'(addr_q[i]), 32'(i * 4));
        chk("full_data", data_q[i],      32'h1000_0000 + 32'(i) * 32'h0000_0101);
      end
      chk("full_last_addr", 32'(addr_q[63]), 32'hFC);
    end
    chk("full_done", 32'(done), 32'd1);
    chk("full_err",  32'(err),  32'd0);

    // Three words with random valid gaps
    do_reset();
    send_word(32'd3, 3);
    send_word(32'hDEAD_BEEF, 3);
    send_word(32'h0123_4567, 3);
    send_word(32'h89AB_CDEF, 3);
    idle();
    repeat (3) @(negedge clk);
    chk("gap_count", 32'(addr_q.size()), 32'd3);
    if (addr_q.size() == 3) begin
      chk("gap_a0", 32'(addr_q[0]), 32'h00);
      chk("gap_d0", data_q[0],      32'hDEAD_BEEF);
      chk("gap_a1", 32'(addr_q[1]), 32'h04);
      chk("gap_d1", data_q[1],      32'h0123_4567);
      chk("gap_a2", 32'(addr_q[2]), 32'h08);
      chk("gap_d2", data_q[2],      32'h89AB_CDEF);
    end
    chk("gap_done", 32'(done), 32'd1);

    // Reset mid-word, then a fresh single-word load
    do_reset();
    send_word(32'd2, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_we",      32'(we),       32'd0);
    chk("mid_waddr",   32'(waddr),    32'd0);
    chk("mid_wdata",   wdata,         32'd0);
    chk("mid_loading", 32'(loading),  32'd1);
    chk("mid_ready",   32'(in_ready), 32'd0);
    chk("mid_done",    32'(done),     32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete();
    data_q.delete();
    send_word(32'd1, 0);
    send_word(32'hDDCC_BBAA, 0);
    idle();
    chk("lat_we",    32'(we),    32'd1);
    chk("lat_waddr", 32'(waddr), 32'h00);
    chk("lat_wdata", wdata,      32'hDDCC_BBAA);
    @(negedge clk);
    chk("re_done",  32'(done), 32'd1);
    chk("re_count", 32'(addr_q.size()), 32'd1);

    // Bytes offered after done are ignored
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_ready", 32'(in_ready), 32'd0);
    end
    idle();
    @(negedge clk);
    chk("post_count", 32'(addr_q.size()), 32'd1);
    chk("post_we",    32'(we),    32'd0);
    chk("post_waddr", 32'(waddr), 32'h00);
    chk("post_wdata", wdata,      32'hDDCC_BBAA);
    chk("post_done",  32'(done),  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
